// File: rtl/riscv_imem_loader_pkg.sv
// Shared configuration for the instruction-memory loader: memory sizes,
// loader FSM encodings and a small state helper.
package riscv_imem_loader_pkg;

  localparam int DMEM_ADDR_BIT = 10;
  localparam int IMEM_ADDR_BIT = 10;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } loader_state_t;

  // Terminal states stop the byte stream until the next reset.
  function automatic logic is_terminal(input loader_state_t s);
    return (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/riscv_byte_packer.sv
// Assembles a little-endian byte stream into 32-bit words and flags the
// accept that completes each word.
module riscv_byte_packer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            byte_valid,
  input  logic            byte_ready,
  input  logic [7:0]      byte_in,
  output logic [1:0]      byte_idx,
  output logic [XLEN-1:0] acc,
  output logic            word_valid
);

  logic accept;

  assign accept = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= 2'd0;
      acc      <= '0;
    end else if (accept) begin
      acc[{byte_idx, 3'b000} +: 8] <= byte_in;
      byte_idx                     <= byte_idx + 2'd1;
    end
  end

  // Combinational so the owner can act on the same edge that takes the last byte.
  always_comb begin
    word_valid = accept && (byte_idx == 2'd3);
  end

endmodule

// File: rtl/riscv_imem_loader.sv
// Framed byte-stream loader: writes COUNT words into IMEM from address 0,
// verifies the checksum and only then releases the core from reset.
module riscv_imem_loader #(
  parameter int XLEN          = 32,
  parameter int IMEM_ADDR_BIT = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_byte_ready,
  output logic            o_im_we,
  output logic [XLEN-1:0] o_im_addr,
  output logic [XLEN-1:0] o_im_wdata,
  output logic            o_core_rstn,
  output logic            o_done,
  output logic            o_error
);

  import riscv_imem_loader_pkg::*;

  localparam int IDX_W = IMEM_ADDR_BIT + 1;
  localparam logic [XLEN-1:0] MAX_WORDS = XLEN'(2 ** IMEM_ADDR_BIT);

  loader_state_t state, next_state;

  logic [1:0]      pk_byte_idx;
  logic [XLEN-1:0] pk_acc;
  logic            pk_word_valid;
  logic [XLEN-1:0] in_word;
  logic            byte_ready;

  logic [IDX_W-1:0] word_count;
  logic [IDX_W-1:0] word_idx;
  logic [XLEN-1:0]  sum;

  riscv_byte_packer #(
    .XLEN(XLEN)
  ) u_packer (
    .clk        (i_clk),
    .rst        (i_rst),
    .byte_valid (i_byte_valid),
    .byte_ready (byte_ready),
    .byte_in    (i_byte),
    .byte_idx   (pk_byte_idx),
    .acc        (pk_acc),
    .word_valid (pk_word_valid)
  );

  // The word being completed: stored lanes overlaid with the byte on the bus.
  always_comb begin
    in_word                            = pk_acc;
    in_word[{pk_byte_idx, 3'b000} +: 8] = i_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_HDR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    byte_ready = !is_terminal(state);
    case (state)
      S_HDR: begin
        if (pk_word_valid) begin
          if (in_word > MAX_WORDS) begin
            next_state = S_ERR;
          end else if (in_word == '0) begin
            next_state = S_CSUM;
          end else begin
            next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pk_word_valid && ((word_idx + IDX_W'(1)) == word_count)) begin
          next_state = S_CSUM;
        end
      end
      S_CSUM: begin
        if (pk_word_valid) begin
          next_state = (in_word == sum) ? S_DONE : S_ERR;
        end
      end
      S_DONE: next_state = S_DONE;
      S_ERR:  next_state = S_ERR;
      default: begin
        next_state = S_ERR;
        byte_ready = 1'b0;
      end
    endcase
  end

  assign o_byte_ready = byte_ready;

  // Word counter, running checksum and the registered IMEM write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_count  <= '0;
      word_idx    <= '0;
      sum         <= '0;
      o_im_we     <= 1'b0;
      o_im_addr   <= '0;
      o_im_wdata  <= '0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_core_rstn <= 1'b0;
    end else begin
      o_im_we <= 1'b0;
      if (pk_word_valid) begin
        case (state)
          S_HDR: begin
            word_count <= IDX_W'(in_word);
            sum        <= in_word;
          end
          S_DATA: begin
            sum        <= sum + in_word;
            o_im_we    <= 1'b1;
            o_im_addr  <= XLEN'({word_idx[IMEM_ADDR_BIT-1:0], 2'b00});
            o_im_wdata <= in_word;
            word_idx   <= word_idx + IDX_W'(1);
          end
          default: begin
          end
        endcase
      end
      o_done      <= (next_state == S_DONE);
      o_core_rstn <= (next_state == S_DONE);
      o_error     <= (next_state == S_ERR);
    end
  end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for the IMEM loader: good/bad checksum, empty and
// oversized frames, full-capacity load, mid-load reset and stalls.
module tb_riscv_imem_loader;

  logic        clk;
  logic        i_rst;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_im_we;
  logic [31:0] o_im_addr;
  logic [31:0] o_im_wdata;
  logic        o_core_rstn;
  logic        o_done;
  logic        o_error;

  int checks = 0;
  int errors = 0;
  int weOverlap = 0;
  logic wePrev = 1'b0;
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  riscv_imem_loader #(
    .XLEN(32),
    .IMEM_ADDR_BIT(10)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_im_we      (o_im_we),
    .o_im_addr    (o_im_addr),
    .o_im_wdata   (o_im_wdata),
    .o_core_rstn  (o_core_rstn),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every IMEM write strobe and catch strobes longer than one cycle.
  always @(negedge clk) begin
    if (o_im_we) begin
      wrAddr.push_back(o_im_addr);
      wrData.push_back(o_im_wdata);
    end
    if (o_im_we && wePrev) weOverlap++;
    wePrev = o_im_we;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      i_byte_valid = 1'b0;
    end
    @(negedge clk);
    i_byte_valid = 1'b1;
    i_byte       = b;
    @(posedge clk);
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(w[8*k +: 8], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
    end
  endtask

  task automatic idleCheckpoint();
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    i_byte_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_ready"}, 32'(o_byte_ready), 32'd1);
    checkOutput({pfx, "_we"},    32'(o_im_we),      32'd0);
    checkOutput({pfx, "_addr"},  o_im_addr,         32'd0);
    checkOutput({pfx, "_wdata"}, o_im_wdata,        32'd0);
    checkOutput({pfx, "_rstn"},  32'(o_core_rstn),  32'd0);
    checkOutput({pfx, "_done"},  32'(o_done),       32'd0);
    checkOutput({pfx, "_error"}, 32'(o_error),      32'd0);
  endtask

  initial begin
    logic [31:0] csum;
    int seqErr;

    i_rst        = 1'b1;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    #1;
    checkResetOutputs("rst");

    // Two-word frame with a correct checksum (COUNT is part of the sum).
    $display("[TB] two-word frame, good checksum");
    resetDut();
    sendWord(32'd2, 0);
    sendWord(32'h00500093, 0);
    sendWord(32'h00100113, 0);
    checkOutput("a_done_early", 32'(o_done), 32'd0);
    sendWord(32'h006001A8, 0);
    idleCheckpoint();
    checkOutput("a_done",  32'(o_done),       32'd1);
    checkOutput("a_rstn",  32'(o_core_rstn),  32'd1);
    checkOutput("a_error", 32'(o_error),      32'd0);
    checkOutput("a_ready", 32'(o_byte_ready), 32'd0);
    settle();
    checkOutput("a_nwr",   32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      checkOutput("a_addr0", wrAddr[0], 32'h0);
      checkOutput("a_data0", wrData[0], 32'h00500093);
      checkOutput("a_addr1", wrAddr[1], 32'h4);
      checkOutput("a_data1", wrData[1], 32'h00100113);
    end

    // Same frame with a wrong checksum.
    $display("[TB] two-word frame, bad checksum");
    resetDut();
    sendWord(32'd2, 0);
    sendWord(32'h00500093, 0);
    sendWord(32'h00100113, 0);
    sendWord(32'h006001A7, 0);
    idleCheckpoint();
    checkOutput("b_error", 32'(o_error),      32'd1);
    checkOutput("b_rstn",  32'(o_core_rstn),  32'd0);
    checkOutput("b_done",  32'(o_done),       32'd0);
    checkOutput("b_ready", 32'(o_byte_ready), 32'd0);
    settle();
    checkOutput("b_nwr", 32'(wrAddr.size()), 32'd2);

    // Empty frame.
    $display("[TB] empty frame");
    resetDut();
    sendWord(32'd0, 0);
    sendWord(32'd0, 0);
    idleCheckpoint();
    checkOutput("c_done", 32'(o_done),      32'd1);
    checkOutput("c_rstn", 32'(o_core_rstn), 32'd1);
    settle();
    checkOutput("c_nwr", 32'(wrAddr.size()), 32'd0);

    // Oversized COUNT: rejected right after the header, later bytes ignored.
    $display("[TB] oversized frame");
    resetDut();
    sendWord(32'h00000401, 0);
    idleCheckpoint();
    checkOutput("d_error", 32'(o_error),      32'd1);
    checkOutput("d_ready", 32'(o_byte_ready), 32'd0);
    sendWord(32'hCAFEF00D, 0);
    idleCheckpoint();
    settle();
    checkOutput("d_nwr",   32'(wrAddr.size()), 32'd0);
    checkOutput("d_error2", 32'(o_error), 32'd1);

    // Full-capacity frame with DATA[i] = i.
    $display("[TB] full-capacity frame");
    resetDut();
    csum = 32'h400;
    sendWord(32'h400, 0);
    for (int i = 0; i < 1024; i++) begin
      sendWord(32'(i), 0);
      csum = csum + 32'(i);
    end
    checkOutput("e_csum_model", csum, 32'h00080200);
    sendWord(csum, 0);
    idleCheckpoint();
    checkOutput("e_done", 32'(o_done), 32'd1);
    settle();
    checkOutput("e_nwr", 32'(wrAddr.size()), 32'd1024);
    if (wrAddr.size() == 1024) begin
      checkOutput("e_last_addr", wrAddr[1023], 32'h00000FFC);
      checkOutput("e_last_data", wrData[1023], 32'h000003FF);
      seqErr = 0;
      for (int i = 0; i < 1024; i++) begin
        if (wrAddr[i] !== 32'(i << 2) || wrData[i] !== 32'(i)) seqErr++;
      end
      checkOutput("e_seq", 32'(seqErr), 32'd0);
    end

    // Reset after six data bytes, then a fresh frame with random stalls.
    $display("[TB] mid-load reset and stalled reload");
    resetDut();
    sendWord(32'd2, 0);
    sendWord(32'hDEADBEEF, 0);
    applyStimulus(8'h78, 0);
    applyStimulus(8'h56, 0);
    resetDut();
    checkResetOutputs("m");
    sendWord(32'd3, 3);
    sendWord(32'h11111111, 3);
    sendWord(32'h22222222, 3);
    sendWord(32'h33333333, 3);
    sendWord(32'h66666669, 3);
    idleCheckpoint();
    checkOutput("m_done", 32'(o_done), 32'd1);
    settle();
    checkOutput("m_nwr", 32'(wrAddr.size()), 32'd3);
    if (wrAddr.size() == 3) begin
      checkOutput("m_addr2", wrAddr[2], 32'h8);
      checkOutput("m_data0", wrData[0], 32'h11111111);
      checkOutput("m_data2", wrData[2], 32'h33333333);
    end
    checkOutput("we_single_cycle", 32'(weOverlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
